// File: rtl/stopwatch_pkg.sv
// Shared state encodings and tick-divider constants for the stopwatch sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int TICK_DIV_DEFAULT = 1000000;
  localparam int TICK_DIV_SIM     = 4;

endpackage

// File: rtl/stopwatch_lap_ctl_edge_rise.sv
// Rising-edge detector; the history bit resets to 1 so a level held through reset gives no edge.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b1;
    else       q <= in;
  end

  assign rise = in & ~q;

endmodule

// File: rtl/stopwatch_lap_ctl.sv
// Edge-driven stopwatch sequencer: idle/run/pause/lap FSM, count-tick prescaler, lap capture pulse.
module stopwatch_lap_ctl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic       split,
  output logic       init_regs,
  output logic       count_enabled,
  output logic       tick,
  output logic       lap_load,
  output logic       disp_freeze,
  output logic [1:0] state_o
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre;
  logic             trig_r, split_r;

  edge_rise u_trig_edge (
    .clk   (clk),
    .reset (reset),
    .in    (trig),
    .rise  (trig_r)
  );

  edge_rise u_split_edge (
    .clk   (clk),
    .reset (reset),
    .in    (split),
    .rise  (split_r)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // trig is tested first in every state so it wins over a simultaneous split.
  always_comb begin
    state_d       = state_q;
    init_regs     = 1'b0;
    count_enabled = 1'b0;
    disp_freeze   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        init_regs = 1'b1;
        if (trig_r) state_d = ST_RUN;
      end
      ST_RUN: begin
        count_enabled = 1'b1;
        if (trig_r)       state_d = ST_PAUSE;
        else if (split_r) state_d = ST_LAP;
      end
      ST_LAP: begin
        count_enabled = 1'b1;
        disp_freeze   = 1'b1;
        if (trig_r)       state_d = ST_PAUSE;
        else if (split_r) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (trig_r)       state_d = ST_RUN;
        else if (split_r) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) lap_load <= 1'b0;
    else       lap_load <= (state_q == ST_RUN) && (state_d == ST_LAP);
  end

  // Holding in PAUSE keeps the partial tick period across a pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else begin
      case (state_q)
        ST_IDLE:  pre <= '0;
        ST_PAUSE: pre <= pre;
        default:  pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      endcase
    end
  end

  assign tick    = count_enabled & (pre == PRE_MAX);
  assign state_o = state_q;

endmodule

// File: doc/stopwatch_lap_ctl.md
Name: stopwatch_lap_ctl

Overview:
Stopwatch sequencer with lap (split-time) support. It replaces the level-sensitive start/stop control with an edge-driven state machine that has four states: idle, run, pause, lap. It also produces the prescaled count tick for the time-counter datapath and the capture/freeze controls for the display register. It sits between the debounced/synchronised push-buttons and the counter and display datapath.

Parameters:
TICK_DIV, 1000000, number of clk cycles per count tick (100 MHz clock gives a 10 ms tick); legal range is 2 or more.
PRE_W, $clog2(TICK_DIV), width of the prescaler counter; derived, never overridden.

Ports:
clk  in  1  system clock; all logic updates on its rising edge.
reset  in  1  synchronous, active-high reset.
trig  in  1  start/stop button level, already debounced and synchronised.
split  in  1  lap/clear button level, already debounced and synchronised.
init_regs  out  1  clears the time counters; high in IDLE.
count_enabled  out  1  counters may advance; high in RUN and LAP.
tick  out  1  one-cycle count-advance pulse for the counters.
lap_load  out  1  one-cycle pulse; display register captures the live count.
disp_freeze  out  1  display shows the captured value instead of the live count; high in LAP.
state_o  out  2  current state, for debug LEDs.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Edge detection:
  - trig_q and split_q are registered copies of the inputs.
  - Rising edge is defined as trig_r = trig & ~trig_q (split_r likewise).
  - While reset is high, trig_q and split_q load 1. A button held through reset therefore produces no edge; it must be released and pressed again.
- States and encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3. Reset state is IDLE.
- Transitions are evaluated at the clock edge where the rising-edge term is true:
  - IDLE: trig_r -> RUN. split_r is ignored.
  - RUN: trig_r -> PAUSE. Otherwise split_r -> LAP.
  - LAP: trig_r -> PAUSE, which releases the freeze. Otherwise split_r -> RUN, which also releases the freeze.
  - PAUSE: trig_r -> RUN. Otherwise split_r -> IDLE, which clears the counters.
- Priority: trig_r beats split_r when both occur on the same clock edge.
- Outputs:
  - init_regs, count_enabled, disp_freeze and state_o are Moore outputs decoded from the state register. They change in the cycle immediately after the edge that changes state.
  - Latency from the first clk edge sampling a button high to the output change is 1 cycle.
- lap_load:
  - Registered pulse, high exactly one cycle: the first cycle in LAP after a RUN->LAP transition.
  - Never asserted on any other transition.
- Prescaler pre (PRE_W bits):
  - Reset value 0. Forced to 0 in IDLE.
  - Holds its value in PAUSE, so fractional tick time is preserved across a pause.
  - In RUN or LAP it increments, wrapping from TICK_DIV-1 to 0.
- tick = count_enabled & (pre == TICK_DIV-1), combinational and high one cycle per wrap. If the state leaves RUN on that same edge, tick is still high in that cycle.
- Reset values: state IDLE, init_regs=1, count_enabled=0, tick=0, lap_load=0, disp_freeze=0, state_o=0, pre=0.
- Reset mid-operation from any state: IDLE on the next edge, prescaler cleared, freeze released. reset overrides all button edges in the same cycle.
- The block holds no counter value of its own; the time count lives in the datapath.

Decomposition:
- Shared package/header stopwatch_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP;
  - the default TICK_DIV;
  - the simulation TICK_DIV (4).
- One sub-module, edge_rise: a 1-bit register with synchronous reset-to-1, output in & ~q. It is instantiated twice, for trig and for split.
- The FSM, prescaler and lap_load register stay in stopwatch_lap_ctl.

Test Plan:
1. Reset plus a held button. Conditions: TICK_DIV=4; reset=1 for 2 cycles with trig=1; release reset; keep trig=1 for 3 cycles. Required: state_o stays 0, init_regs=1, count_enabled=0, tick never high. Then drop trig and raise it again: RUN one cycle later.
2. Run and tick. From IDLE, one trig press. Required: count_enabled=1 one cycle after the edge; tick high every 4th cycle; 12 cycles in RUN give exactly 3 ticks.
3. Lap. In RUN, press split. Required: state_o=3, disp_freeze=1, lap_load high exactly one cycle, ticks continue every 4 cycles. Press split again: state_o=1, disp_freeze=0, no lap_load.
4. Pause preserves the prescaler and clears. RUN for 6 cycles (pre=2), then trig: PAUSE, no ticks for 10 cycles. trig again: first tick 2 cycles after RUN resumes. In PAUSE, split -> IDLE with init_regs=1 and pre=0.
5. Simultaneous edges. In RUN, raise trig and split on the same cycle. Required: PAUSE, lap_load=0. In LAP, raise both: PAUSE with disp_freeze=0.
6. Reset mid-LAP. reset=1 for one cycle while in LAP with pre=3. Required: next cycle state_o=0, disp_freeze=0, tick=0, count_enabled=0.
